// File: rtl/cva6v_mem_port_responder.sv
// cva6v_mem_port_responder
// Target-side responder for one vector memory port. It checks each accepted
// request for alignment and range, drives a single-port SRAM macro, and
// returns exactly one in-order response per request at a fixed latency.
// Optional feature macro: CVA6V_MEM_RSP_CUT_EN adds one register stage on the
// response outputs. This raises the latency to ReadLatency+1 and fully
// registers rdata.
module cva6v_mem_port_responder #(
    parameter int unsigned MemPortWidth     = 128,
    parameter int unsigned MemPortAddrWidth = 22,
    parameter int unsigned MemDepth         = 4096,
    parameter int unsigned ReadLatency      = 1,
    localparam int unsigned BeW             = MemPortWidth / 8,
    localparam int unsigned WAddrW          = $clog2(MemDepth),
    localparam int unsigned OffW            = $clog2(BeW)
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_mem_req_valid,
    output logic                        o_mem_req_ready,
    input  logic [MemPortAddrWidth-1:0] i_mem_req_addr,
    input  logic                        i_mem_req_we,
    input  logic [BeW-1:0]              i_mem_req_be,
    input  logic [MemPortWidth-1:0]     i_mem_req_wdata,
    output logic                        o_mem_res_valid,
    output logic [MemPortWidth-1:0]     o_mem_res_rdata,
    output logic                        o_mem_res_err,
    input  logic                        i_sram_gnt,
    output logic                        o_sram_ce,
    output logic                        o_sram_we,
    output logic [WAddrW-1:0]           o_sram_addr,
    output logic [BeW-1:0]              o_sram_wbe,
    output logic [MemPortWidth-1:0]     o_sram_wdata,
    input  logic [MemPortWidth-1:0]     i_sram_rdata,
    output logic [15:0]                 o_err_count,
    output logic                        o_busy
);

    // One response-pipeline entry. Invalid entries always carry err=0 and
    // is_read=0, so the output stage never needs to re-qualify them.
    typedef struct packed {
        logic valid;
        logic err;
        logic is_read;
    } stage_t;

    logic                        hs;
    logic                        req_err;
    logic                        req_good;
    logic [MemPortAddrWidth-1:0] word_idx;
    stage_t                      pipe [ReadLatency];
    stage_t                      last;
    logic                        res_valid_d;
    logic                        res_err_d;
    logic [MemPortWidth-1:0]     res_rdata_d;

    assign o_mem_req_ready = i_sram_gnt & ~i_rst;
    assign hs              = i_mem_req_valid & o_mem_req_ready;
    assign word_idx        = i_mem_req_addr >> OffW;
    assign req_err         = (i_mem_req_addr[OffW-1:0] != '0) ||
                             (word_idx >= MemPortAddrWidth'(MemDepth));
    assign req_good        = hs & ~req_err;

    // Macro access is combinational from the handshake; idle or errored cycles drive zeros.
    always_comb begin
        // NOTE: every output gets a default first, so no path through the block can infer a latch.
        o_sram_ce    = 1'b0;
        o_sram_we    = 1'b0;
        o_sram_addr  = '0;
        o_sram_wbe   = '0;
        o_sram_wdata = '0;
        if (req_good) begin
            o_sram_ce    = 1'b1;
            o_sram_we    = i_mem_req_we;
            o_sram_addr  = i_mem_req_addr[OffW +: WAddrW];
            o_sram_wbe   = i_mem_req_we ? i_mem_req_be : '0;
            o_sram_wdata = i_mem_req_wdata;
        end
    end

    // Fixed-latency response shift register, loaded every cycle with this cycle's handshake.
    always_ff @(posedge i_clk) begin
        // NOTE: the valid bits must be cleared on reset so that in-flight requests are dropped;
        // state updates use non-blocking assignments so every stage shifts from pre-edge values.
        if (i_rst) begin
            for (int i = 0; i < int'(ReadLatency); i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= '{valid: hs, err: hs & req_err, is_read: hs & ~i_mem_req_we};
            for (int i = 1; i < int'(ReadLatency); i++) pipe[i] <= pipe[i-1];
        end
    end

    // Busy while any pipeline stage holds a response.
    always_comb begin
        o_busy = 1'b0;
        for (int i = 0; i < int'(ReadLatency); i++) o_busy = o_busy | pipe[i].valid;
    end

    assign last        = pipe[ReadLatency-1];
    assign res_valid_d = last.valid;
    assign res_err_d   = last.err;
    assign res_rdata_d = (last.valid & last.is_read & ~last.err) ? i_sram_rdata : '0;

`ifdef CVA6V_MEM_RSP_CUT_EN
    // Extra output register that fully registers the response, including rdata.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_mem_res_valid <= 1'b0;
            o_mem_res_err   <= 1'b0;
            o_mem_res_rdata <= '0;
        end else begin
            o_mem_res_valid <= res_valid_d;
            o_mem_res_err   <= res_err_d;
            o_mem_res_rdata <= res_rdata_d;
        end
    end
`else
    assign o_mem_res_valid = res_valid_d;
    assign o_mem_res_err   = res_err_d;
    assign o_mem_res_rdata = res_rdata_d;
`endif

    // Saturating count of errored requests.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_err_count <= '0;
        end else if (hs && req_err && (o_err_count != 16'hFFFF)) begin
            o_err_count <= o_err_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_cva6v_mem_port_responder.sv
// Self-checking bench for cva6v_mem_port_responder. It contains a behavioural
// SRAM macro and a queue-based reference model of the expected responses.
// It also works with CVA6V_MEM_RSP_CUT_EN defined, where the latency is one
// cycle longer.
module tb_cva6v_mem_port_responder;

    localparam int W     = 128;
    localparam int AW    = 22;
    localparam int DEPTH = 4096;
    localparam int RL    = 2;
    localparam int BEW   = W / 8;
    localparam int WA    = 12;
`ifdef CVA6V_MEM_RSP_CUT_EN
    localparam int LAT = RL + 1;
`else
    localparam int LAT = RL;
`endif

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic          req_we;
    logic [BEW-1:0] req_be;
    logic [W-1:0]  req_wdata;
    logic          res_valid;
    logic [W-1:0]  res_rdata;
    logic          res_err;
    logic          sram_gnt;
    logic          sram_ce;
    logic          sram_we;
    logic [WA-1:0] sram_addr;
    logic [BEW-1:0] sram_wbe;
    logic [W-1:0]  sram_wdata;
    logic [W-1:0]  sram_rdata;
    logic [15:0]   err_count;
    logic          busy;

    cva6v_mem_port_responder #(
        .MemPortWidth(W), .MemPortAddrWidth(AW), .MemDepth(DEPTH), .ReadLatency(RL)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .i_mem_req_valid(req_valid), .o_mem_req_ready(req_ready),
        .i_mem_req_addr(req_addr), .i_mem_req_we(req_we),
        .i_mem_req_be(req_be), .i_mem_req_wdata(req_wdata),
        .o_mem_res_valid(res_valid), .o_mem_res_rdata(res_rdata), .o_mem_res_err(res_err),
        .i_sram_gnt(sram_gnt), .o_sram_ce(sram_ce), .o_sram_we(sram_we),
        .o_sram_addr(sram_addr), .o_sram_wbe(sram_wbe), .o_sram_wdata(sram_wdata),
        .i_sram_rdata(sram_rdata), .o_err_count(err_count), .o_busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM macro: read data appears RL cycles after ce. Otherwise it drives junk.
    logic [W-1:0] sram_mem [DEPTH];
    logic [W-1:0] rd_pipe  [RL];
    assign sram_rdata = rd_pipe[RL-1];

    always @(posedge clk) begin
        if (sram_ce && sram_we)
            for (int b = 0; b < BEW; b++)
                if (sram_wbe[b]) sram_mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
        rd_pipe[0] <= (sram_ce && !sram_we) ? sram_mem[sram_addr]
                                            : {$urandom, $urandom, $urandom, $urandom};
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    // Reference model: word memory plus a queue of expected responses.
    typedef struct {
        int           acc;
        int           due;
        bit           err;
        logic [W-1:0] rdata;
    } exp_t;

    logic [W-1:0] ref_mem [DEPTH];
    exp_t         expq [$];
    int           cyc;
    int           err_cnt_ref;
    bit           rsp_chk;
    int           n_cmp;
    int           n_bad;

    // Drives one cycle of stimulus. It compares the combinational and
    // registered outputs mid-cycle, then advances the reference model.
    task automatic step(input bit v, input bit we, input logic [AW-1:0] addr,
                        input logic [BEW-1:0] be, input logic [W-1:0] wd,
                        input bit gnt, input bit r);
        bit           acc, bad, exp_valid, exp_err, exp_busy;
        logic [W-1:0] exp_rdata;
        int           widx;
        exp_t         e;
        req_valid = v; req_we = we; req_addr = addr; req_be = be; req_wdata = wd;
        sram_gnt = gnt; rst = r;
        @(negedge clk);
        acc  = v && gnt && !r;
        bad  = (int'(addr) % BEW != 0) || (int'(addr) / BEW >= DEPTH);
        widx = int'(addr) / BEW;

        n_cmp++;
        if (req_ready !== (gnt && !r)) begin
            n_bad++; $display("FAIL ready cyc=%0d: got %b expected %b", cyc, req_ready, gnt && !r);
        end
        n_cmp++;
        if (sram_ce !== (acc && !bad)) begin
            n_bad++; $display("FAIL sram_ce cyc=%0d: got %b expected %b", cyc, sram_ce, acc && !bad);
        end
        if (acc && !bad) begin
            n_cmp++;
            if (sram_we !== we || sram_addr !== WA'(widx) || sram_wbe !== (we ? be : '0) || sram_wdata !== wd) begin
                n_bad++;
                $display("FAIL sram_req cyc=%0d: got we=%b addr=%h wbe=%h wdata=%h expected we=%b addr=%h wbe=%h wdata=%h",
                         cyc, sram_we, sram_addr, sram_wbe, sram_wdata, we, WA'(widx), we ? be : '0, wd);
            end
        end
        if (r) begin
            n_cmp++;
            if ({sram_we, sram_addr, sram_wbe, sram_wdata} !== '0) begin
                n_bad++; $display("FAIL sram_in_reset cyc=%0d: got we=%b addr=%h wbe=%h expected all 0",
                                  cyc, sram_we, sram_addr, sram_wbe);
            end
        end

        exp_busy = 1'b0;
        foreach (expq[i]) if (expq[i].acc >= cyc - RL && expq[i].acc < cyc) exp_busy = 1'b1;
        exp_valid = 1'b0; exp_err = 1'b0; exp_rdata = '0;
        if (expq.size() > 0 && expq[0].due == cyc) begin
            e = expq.pop_front();
            exp_valid = 1'b1; exp_err = e.err; exp_rdata = e.rdata;
        end
        if (rsp_chk) begin
            n_cmp++;
            if (res_valid !== exp_valid || res_err !== exp_err || res_rdata !== exp_rdata) begin
                n_bad++;
                $display("FAIL response cyc=%0d: got v=%b err=%b rdata=%h expected v=%b err=%b rdata=%h",
                         cyc, res_valid, res_err, res_rdata, exp_valid, exp_err, exp_rdata);
            end
            n_cmp++;
            if (busy !== exp_busy) begin
                n_bad++; $display("FAIL busy cyc=%0d: got %b expected %b", cyc, busy, exp_busy);
            end
            n_cmp++;
            if (err_count !== 16'(err_cnt_ref)) begin
                n_bad++; $display("FAIL err_count cyc=%0d: got %0d expected %0d", cyc, err_count, err_cnt_ref);
            end
        end

        if (acc) begin
            e.acc = cyc; e.due = cyc + LAT; e.err = bad; e.rdata = '0;
            if (!bad) begin
                if (we) begin
                    for (int b = 0; b < BEW; b++) if (be[b]) ref_mem[widx][b*8 +: 8] = wd[b*8 +: 8];
                end else begin
                    e.rdata = ref_mem[widx];
                end
            end else if (err_cnt_ref < 65535) begin
                err_cnt_ref++;
            end
            expq.push_back(e);
        end
        if (r) begin
            expq.delete();
            err_cnt_ref = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, '0, '0, 1, 0);
    endtask

    task automatic drain(input string name);
        idle(LAT + 2);
        n_cmp++;
        if (expq.size() != 0) begin
            n_bad++; $display("FAIL %s_drain: got %0d responses outstanding expected 0", name, expq.size());
        end
    endtask

    task automatic test_reset;
        step(1, 1, 'h40, '1, '1, 1, 1);
        rsp_chk = 1'b1;
        step(1, 0, 'h40, '1, '1, 1, 1);
        n_cmp++;
        if ({res_valid, res_err, busy, req_ready} !== 4'b0 || res_rdata !== '0 || err_count !== 16'd0) begin
            n_bad++; $display("FAIL reset_values: got v=%b err=%b busy=%b rdy=%b cnt=%0d expected all 0",
                              res_valid, res_err, busy, req_ready, err_count);
        end
    endtask

    task automatic test_write_read;
        step(1, 1, 'h40, '1, {16{8'hA5}}, 1, 0);
        step(1, 0, 'h40, '0, '0, 1, 0);
        drain("write_read");
    endtask

    task automatic test_partial_write;
        step(1, 1, 'h40, '1, '0, 1, 0);
        step(1, 1, 'h40, 16'h0001, {{15{8'h5A}}, 8'hFF}, 1, 0);
        step(1, 1, 'h80, 16'h0000, '1, 1, 0);
        step(1, 0, 'h40, '0, '0, 1, 0);
        step(1, 0, 'h80, '0, '0, 1, 0);
        drain("partial_write");
    endtask

    task automatic test_errors;
        step(0, 0, '0, '0, '0, 1, 1);
        step(1, 0, 'h41, '0, '0, 1, 0);
        step(1, 0, AW'(DEPTH * BEW), '0, '0, 1, 0);
        drain("errors");
        n_cmp++;
        if (err_count !== 16'd2) begin
            n_bad++; $display("FAIL error_count_two: got %0d expected 2", err_count);
        end
    endtask

    task automatic test_grant_gaps;
        int accepted;
        int k;
        for (int i = 0; i < 8; i++)
            step(1, 1, AW'(i * BEW), '1, {$urandom, $urandom, $urandom, $urandom}, 1, 0);
        accepted = 0;
        k = 0;
        while (accepted < 8 && k < 40) begin
            step(1, 0, AW'(accepted * BEW), '0, '0, (k % 3) != 2, 0);
            if ((k % 3) != 2) accepted++;
            k++;
        end
        drain("grant_gaps");
        n_cmp++;
        if (accepted != 8) begin
            n_bad++; $display("FAIL grant_gaps_count: got %0d expected 8", accepted);
        end
    endtask

    task automatic test_random;
        logic [AW-1:0] a;
        for (int i = 0; i < 400; i++) begin
            a = AW'($urandom_range(0, 63) * BEW);
            if ($urandom_range(0, 9) == 0) a = AW'($urandom);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a, BEW'($urandom),
                 {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 4) != 0, 0);
        end
        drain("random");
    endtask

    task automatic test_reset_midflight;
        step(1, 1, 'h100, '1, {$urandom, $urandom, $urandom, $urandom}, 1, 0);
        idle(LAT + 1);
        step(1, 0, 'h100, '0, '0, 1, 0);
        step(1, 0, 'h100, '0, '0, 1, 1);
        idle(LAT + 1);
        n_cmp++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || res_rdata !== '0) begin
            n_bad++; $display("FAIL reset_midflight: got busy=%b v=%b rdata=%h expected 0", busy, res_valid, res_rdata);
        end
    endtask

    task automatic test_saturation;
        step(0, 0, '0, '0, '0, 1, 1);
        for (int i = 0; i < 65538; i++) step(1, 0, 'h1, '0, '0, 1, 0);
        drain("saturation");
        n_cmp++;
        if (err_count !== 16'hFFFF) begin
            n_bad++; $display("FAIL err_count_saturate: got %h expected ffff", err_count);
        end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0; err_cnt_ref = 0; rsp_chk = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            sram_mem[i] = '0;
            ref_mem[i]  = '0;
        end
        for (int i = 0; i < RL; i++) rd_pipe[i] = '0;
        test_reset();
        test_write_read();
        test_partial_write();
        test_errors();
        test_grant_gaps();
        test_random();
        test_reset_midflight();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cva6v_mem_port_responder.md
# cva6v_mem_port_responder

Target-side responder for one Raptor vector memory port of the CVA6V core. It accepts requests from the `mem_req_*` handshake, checks each request, and drives a single-port SRAM macro. It returns exactly one in-order response per accepted request on `mem_res_*`, at a fixed latency. It sits in the AI-core memory subsystem, one instance per `MemPortCount` lane, between the core wrapper and a TCDM bank.

## Interface
- MemPortWidth, 128, data width in bits; must be a multiple of 8.
- MemPortAddrWidth, 22, byte address width.
- MemDepth, 4096, macro depth in words; must be a power of two.
- ReadLatency, 1, macro read latency in cycles; must be at least 1.
- Derived: BeW = MemPortWidth/8; WAddrW = $clog2(MemDepth); OffW = $clog2(BeW).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous, active-high reset.
- i_mem_req_valid  in  1  request valid.
- o_mem_req_ready  out  1  request ready.
- i_mem_req_addr  in  MemPortAddrWidth  byte address.
- i_mem_req_we  in  1  1 = write.
- i_mem_req_be  in  BeW  write byte enables.
- i_mem_req_wdata  in  MemPortWidth  write data.
- o_mem_res_valid  out  1  response valid. There is no ready; the initiator always accepts.
- o_mem_res_rdata  out  MemPortWidth  read data.
- o_mem_res_err  out  1  request errored.
- i_sram_gnt  in  1  bank arbiter grant for this cycle.
- o_sram_ce  out  1  macro chip enable.
- o_sram_we  out  1  macro write enable.
- o_sram_addr  out  WAddrW  macro word address.
- o_sram_wbe  out  BeW  macro byte write enables.
- o_sram_wdata  out  MemPortWidth  macro write data.
- i_sram_rdata  in  MemPortWidth  macro read data, valid ReadLatency cycles after a read `ce`.
- o_err_count  out  16  saturating count of errored requests.
- o_busy  out  1  at least one response is in flight.

## Operation
- `o_mem_req_ready = i_sram_gnt & ~i_rst`. A request is accepted when `valid & ready` (the handshake, hs).
- Error check on hs. The request errors if either condition holds:
  - `addr[OffW-1:0] != 0` (misaligned);
  - `addr >> OffW >= MemDepth` (out of range).
- Errored request: `o_sram_ce` is held at 0. The response still occupies its slot, with err=1 and rdata=0. `o_err_count` increments and saturates at 16'hFFFF.
- Good request: in the hs cycle the block drives:
  - `o_sram_ce = 1`, `o_sram_we = we`, `o_sram_addr = addr[OffW+:WAddrW]`;
  - `o_sram_wbe = we ? be : 0`, `o_sram_wdata = wdata`.
- A write with `be == 0` is still a good request. It asserts ce with wbe=0 and returns a response with err=0.
- Writes also produce a response, with rdata=0 and err=0.
- Response pipeline: a shift register of depth ReadLatency, one entry per stage holding {valid, err, is_read}. A new entry is loaded on every hs.
  - At the output stage: `res_valid = valid`, `res_err = err`.
  - `res_rdata = (valid & is_read & ~err) ? i_sram_rdata : 0`.
- Back-to-back requests are accepted at one per cycle with no bubbles. Ordering is inherent because latency is fixed.
- `o_busy` = OR of all pipeline valid bits.
- Reset, including mid-operation: all pipeline valid bits are cleared, so no response is emitted for requests in flight. `o_err_count` clears.
- Reset values of outputs:
  - `o_mem_req_ready` = 0;
  - `o_mem_res_valid`, `o_mem_res_err`, `o_busy` = 0;
  - `o_mem_res_rdata` = 0;
  - all `o_sram_*` = 0;
  - `o_err_count` = 0.

## Timing
- Request at cycle T: macro access at T, combinational from hs. The response is valid at T+ReadLatency, or T+ReadLatency+1 when the cut is enabled.
- The latency is identical for reads, writes, and errored requests.
- `i_sram_gnt` low: ready is low, nothing is accepted, and in-flight responses continue unaffected.
- Request/response paths are independent: a new hs and a response emission in the same cycle both proceed.
- `valid` may be withdrawn without hs; nothing happens in that case.
- Macro outputs are combinational from the request inputs. The response outputs are registered, except that rdata comes through from the macro.

## Configuration
- `CVA6V_MEM_RSP_CUT_EN` defined: an extra register stage on {res_valid, res_err, res_rdata}. Latency becomes ReadLatency+1 and the rdata path is fully registered. The register resets to 0.
- Not defined: outputs come from the last pipeline stage, with rdata taken directly from `i_sram_rdata`. Latency is ReadLatency.

## Test plan
- Write then read: write addr=0x40, be=all ones, wdata=0xA5…A5, then read addr=0x40 (ReadLatency=1, no cut) -> write response with err=0, rdata=0 at T+1; read response with rdata=0xA5…A5 at T+2.
- Partial write: fill word 0x40 with 0, write be=16'h0001, wdata LSB=0xFF, then read -> rdata = 0x…00FF.
- Errors: read addr=0x41 (misaligned) and addr=MemDepth*16 (out of range) -> `o_sram_ce` stays 0, responses have err=1, rdata=0, same latency, `o_err_count`=2. Preload `o_err_count` to 0xFFFF with a long error stream -> it stays at 0xFFFF.
- Streaming with grant gaps: 8 reads back-to-back with `i_sram_gnt` toggling 1,1,0,1… -> accepted only on gnt=1, responses in order with data matching, no drop or duplication.
- Reset mid-flight: accept a read at T, assert `i_rst` at T+1 with ReadLatency=2 -> no res_valid at T+2/T+3, `o_busy`=0, and all outputs at their reset values.
- With `CVA6V_MEM_RSP_CUT_EN`: repeat the write-then-read scenario -> every response is one cycle later, with data and err identical.
